// File: rtl/dnn_pkg.sv
// Shared types and constants for the DNN data-movement blocks.
//   rd_state_t  : state encoding of the output RAM reader FSM
//   FIFO_DEPTH  : entries in the reader's output buffer
//   FIFO_CNT_W  : width of an occupancy count that can hold 0..FIFO_DEPTH
package dnn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } rd_state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/out_skid_fifo.sv
// Small output buffer between the RAM read path and the stream port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears storage and pointers)
//   push      : write wdata this cycle (ignored when full and not popping)
//   pop       : drop the head entry this cycle (ignored when empty)
//   wdata     : entry to write
//   rdata     : head entry; stable until popped
//   count     : current occupancy, 0..FIFO_DEPTH
module out_skid_fifo
  import dnn_pkg::*;
#(
  parameter int unsigned W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [W-1:0]          wdata,
  output logic [W-1:0]          rdata,
  output logic [FIFO_CNT_W-1:0] count
);

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  localparam int unsigned P_WIDTH = $clog2(FIFO_DEPTH);

  logic [W-1:0]       mem [FIFO_DEPTH];
  logic [P_WIDTH-1:0] wr_ptr;
  logic [P_WIDTH-1:0] rd_ptr;
  logic               pop_ok;
  logic               push_ok;

  assign pop_ok  = pop && (count != '0);
  assign push_ok = push && ((count != FIFO_CNT_W'(FIFO_DEPTH)) || pop_ok);
  assign rdata   = mem[rd_ptr];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + P_WIDTH'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + P_WIDTH'(1);
      count <= count + FIFO_CNT_W'(push_ok) - FIFO_CNT_W'(pop_ok);
    end
  end

endmodule

// File: rtl/output_ram_reader.sv
// Read-side master for the layer output RAM. A start command captures
// base_addr/len; len consecutive words (address wraps modulo RAM depth) are
// read and streamed on a valid/ready port with out_last on the final beat.
// Optional feature macro: OUTPUT_RAM_READER_ARGMAX_EN (adds max_val/max_idx).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : command pulse, sampled only in IDLE
//   base_addr, len      : burst start address and word count (0..2**A_WIDTH)
//   busy, done          : burst in progress / 1-cycle completion pulse
//   r_addr              : registered RAM read address
//   ram_data            : RAM read data, valid the cycle after r_addr is issued
//   out_data, out_valid : stream payload / valid
//   out_ready           : stream ready
//   out_last            : final beat of the burst
//   max_val, max_idx    : (macro only) largest word of the burst and its offset
module output_ram_reader
  import dnn_pkg::*;
#(
  parameter int unsigned D_WIDTH = 4,
  parameter int unsigned A_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [A_WIDTH-1:0] base_addr,
  input  logic [A_WIDTH:0]   len,
  output logic               busy,
  output logic               done,
  output logic [A_WIDTH-1:0] r_addr,
  input  logic [D_WIDTH-1:0] ram_data,
  output logic [D_WIDTH-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
`ifdef OUTPUT_RAM_READER_ARGMAX_EN
  ,
  output logic [D_WIDTH-1:0] max_val,
  output logic [A_WIDTH-1:0] max_idx
`endif
);

  localparam int unsigned L_WIDTH = A_WIDTH + 1;
  localparam int unsigned E_WIDTH = D_WIDTH + 1;
  localparam int unsigned S_WIDTH = FIFO_CNT_W + 1;

  rd_state_t             state_q;
  rd_state_t             state_n;
  logic [A_WIDTH-1:0]    base_q;
  logic [L_WIDTH-1:0]    len_q;
  logic [L_WIDTH-1:0]    issue_cnt;
  logic [L_WIDTH-1:0]    push_cnt;
  logic                  inflight;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [E_WIDTH-1:0]    fifo_wdata;
  logic [E_WIDTH-1:0]    fifo_rdata;
  logic                  accept;
  logic                  issue;
  logic                  pop;
  logic                  push;
  logic                  push_last;
  logic                  room;

  assign accept    = (state_q == IDLE) && start;
  assign pop       = out_valid && out_ready;
  assign push      = inflight;
  assign push_last = (push_cnt == len_q - L_WIDTH'(1));
  assign fifo_wdata = {push_last, ram_data};

  // A slot is free if buffered + in-flight words leave space, or if the head
  // is leaving this cycle; the pop credit is what sustains 1 beat/cycle.
  assign room = ((S_WIDTH'(fifo_count) + S_WIDTH'(inflight)) < S_WIDTH'(FIFO_DEPTH)) || pop;

  assign out_valid = (fifo_count != '0);
  assign out_data  = fifo_rdata[D_WIDTH-1:0];
  assign out_last  = fifo_rdata[D_WIDTH];

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // FSM next-state and issue decision.
  always_comb begin
    state_n = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE:    if (start) state_n = (len == '0) ? FIN : READ;
      READ:    if (issue_cnt == len_q) state_n = DRAIN;
               else issue = room;
      DRAIN:   if (pop && out_last) state_n = FIN;
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command capture, address counter and status outputs. The first address
  // goes out with the accepted start so data reaches the stream two cycles on.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      r_addr    <= '0;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      push_cnt  <= '0;
      inflight  <= 1'b0;
    end else begin
      busy     <= (state_n != IDLE);
      done     <= (state_n == FIN);
      inflight <= 1'b0;
      if (accept) begin
        base_q   <= base_addr;
        len_q    <= len;
        push_cnt <= '0;
        if (len != '0) begin
          r_addr    <= base_addr;
          issue_cnt <= L_WIDTH'(1);
          inflight  <= 1'b1;
        end else begin
          issue_cnt <= '0;
        end
      end else begin
        if (issue) begin
          r_addr    <= base_q + issue_cnt[A_WIDTH-1:0];
          issue_cnt <= issue_cnt + L_WIDTH'(1);
          inflight  <= 1'b1;
        end
        if (push) push_cnt <= push_cnt + L_WIDTH'(1);
      end
    end
  end

  out_skid_fifo #(
    .W(E_WIDTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .wdata(fifo_wdata),
    .rdata(fifo_rdata),
    .count(fifo_count)
  );

`ifdef OUTPUT_RAM_READER_ARGMAX_EN
  // Running maximum over pushed words; strict compare keeps the earliest tie.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (push && (ram_data > max_val)) begin
      max_val <= ram_data;
      max_idx <= push_cnt[A_WIDTH-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_output_ram_reader.sv
// Bench for output_ram_reader: directed timing cases plus randomized bursts
// against a queue model built from the burst definition.
module tb_output_ram_reader;

  localparam int unsigned DW    = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] ram_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
`ifdef OUTPUT_RAM_READER_ARGMAX_EN
  logic [DW-1:0] max_val;
  logic [AW-1:0] max_idx;
`endif

  logic [DW-1:0] mem [DEPTH];
  assign ram_data = mem[r_addr];

  always #5 clk = ~clk;

  output_ram_reader #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .r_addr   (r_addr),
    .ram_data (ram_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
`ifdef OUTPUT_RAM_READER_ARGMAX_EN
    ,
    .max_val  (max_val),
    .max_idx  (max_idx)
`endif
  );

  int            tests = 0;
  int            fails = 0;
  bit            rnd_ready = 1'b0;
  beat_t         exp_q[$];
  beat_t         mon_e;
  logic [DW-1:0] exp_max;
  logic [AW-1:0] exp_idx;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected beats for a burst: word i is mem[(b+i) mod depth], last at len-1.
  task automatic load_model(input logic [AW-1:0] b, input logic [LW-1:0] l);
    beat_t e;
    exp_max = '0;
    exp_idx = '0;
    for (int i = 0; i < int'(l); i++) begin
      e.data = mem[b + AW'(i)];
      e.last = (i == int'(l) - 1);
      exp_q.push_back(e);
      if (e.data > exp_max) begin
        exp_max = e.data;
        exp_idx = AW'(i);
      end
    end
  endtask

  // Bounded wait for done, then end-of-burst checks.
  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(seen), 1);
    check("beats_left", exp_q.size(), 0);
`ifdef OUTPUT_RAM_READER_ARGMAX_EN
    check("max_val", 32'(max_val), 32'(exp_max));
    check("max_idx", 32'(max_idx), 32'(exp_idx));
`endif
    @(negedge clk);
    check("done_pulse", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    exp_q.delete();
  endtask

  task automatic run_burst(input logic [AW-1:0] b, input logic [LW-1:0] l, input bit inject);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l;
    load_model(b, l);
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); len = LW'($urandom_range(0, 16));
    if (inject && l != '0) begin
      // Sampled while the burst is still active, so it must be ignored.
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
    end
    wait_done();
  endtask

  // out_ready driver: held high, or random when rnd_ready is set.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Stream monitor: in-order beats against the model, stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(out_valid), 1);
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_last", 32'(out_last), 32'(prev_last));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 32'(out_valid), 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 32'(out_data), 32'(mon_e.data));
          check("beat_last", 32'(out_last), 32'(mon_e.last));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt, dcnt, bcnt;
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_r_addr", 32'(r_addr), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_last", 32'(out_last), 0);
    check("rst_data", 32'(out_data), 0);
    @(posedge clk); #1; rst = 1'b0;

    // Full-depth burst, ready high: consecutive beats, done right after last.
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = LW'(16);
    load_model('0, LW'(16));
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    check("lat_valid_early", 32'(out_valid), 0);
    check("busy_after_start", 32'(busy), 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("seq_valid", 32'(out_valid), 1);
      check("seq_data", 32'(out_data), 32'(k));
      check("seq_last", 32'(out_last), 32'(k == 15));
    end
    @(negedge clk);
    check("full_done", 32'(done), 1);
    check("full_valid_off", 32'(out_valid), 0);
    check("full_beats_left", exp_q.size(), 0);
    @(negedge clk);
    check("full_done_off", 32'(done), 0);
    check("full_busy_off", 32'(busy), 0);

    // Address wrap: 14,15,0,1.
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(14); len = LW'(4);
    load_model(AW'(14), LW'(4));
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("wrap_r_addr", 32'(r_addr), 32'((14 + k) % 16));
    end
    wait_done();

    // len = 0: no beats, one done, busy only in FIN.
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(5); len = '0;
    @(posedge clk); #1; start = 1'b0;
    vcnt = 0; dcnt = 0; bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      vcnt += int'(out_valid); dcnt += int'(done); bcnt += int'(busy);
    end
    check("len0_valid", 32'(vcnt), 0);
    check("len0_done", 32'(dcnt), 1);
    check("len0_busy", 32'(bcnt), 1);

    // Reset during the third beat of a len=8 burst.
    @(posedge clk); #1;
    start = 1'b1; base_addr = '0; len = LW'(8);
    load_model('0, LW'(8));
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    dcnt = int'(done);
    repeat (5) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    check("mid_rst_no_done", 32'(dcnt), 0);
    run_burst(AW'(3), LW'(8), 1'b0);

    // Start while busy is ignored.
    run_burst(AW'(9), LW'(5), 1'b1);

    // Argmax pattern {3,9,2,9,0...}: max 9 at offset 1.
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    mem[0] = DW'(3); mem[1] = DW'(9); mem[2] = DW'(2); mem[3] = DW'(9);
    run_burst('0, LW'(4), 1'b0);

    // Random bursts with random backpressure.
    rnd_ready = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      if (b % 50 == 0)
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'($urandom);
      run_burst(AW'($urandom), LW'($urandom_range(0, 16)), ($urandom_range(0, 3) == 0));
    end
    rnd_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
